// File: rtl/cb_dina_wb_if.sv
// Write-back stream bundle: TB read-data input handshake plus the CB write port.
// Handshake: a word transfers on a rising clk edge where in_valid && in_ready are both high.
interface cb_dina_wb_if #(
  parameter int L      = 4,
  parameter int RSA_DW = 32,
  parameter int CB_AW  = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [L*RSA_DW-1:0]   TB_douta;
  logic [L*RSA_DW-1:0]   CB_dina;
  logic [L-1:0]          CB_wea;
  logic                  CB_ena;
  logic [CB_AW-1:0]      CB_addra;

  modport master (
    output in_valid, TB_douta,
    input  in_ready, CB_dina, CB_wea, CB_ena, CB_addra
  );

  modport slave (
    input  in_valid, TB_douta,
    output in_ready, CB_dina, CB_wea, CB_ena, CB_addra
  );
endinterface

// File: rtl/cb_dina_wb.sv
// Bursts TB read words into CB memory, reordering lanes by the latched select.
// Every output is a register; a word accepted on edge N is written to CB on edge N+1.
module cb_dina_wb #(
  parameter int X              = 4,
  parameter int L              = 4,
  parameter int RSA_DW         = 32,
  parameter int CB_AW          = 10,
  parameter int SEQ_CNT_DW     = 10,
  parameter int CB_DINA_SEL_DW = 5
) (
  input  logic                      clk,
  input  logic                      sys_rst_n,
  input  logic                      start,
  input  logic [CB_AW-1:0]          base_addr,
  input  logic [SEQ_CNT_DW-1:0]     len,
  input  logic [CB_DINA_SEL_DW-1:0] CB_dina_sel,
  input  logic                      l_k_0,
  cb_dina_wb_if.slave               bus,
  output logic [SEQ_CNT_DW-1:0]     seq_cnt_out,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                o_dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;

  localparam logic [SEQ_CNT_DW-1:0] ONE_CNT = 1;

  state_t                      r_state;
  state_t                      w_next;
  logic [CB_AW-1:0]            r_base;
  logic [SEQ_CNT_DW-1:0]       r_len;
  logic [CB_DINA_SEL_DW-1:0]   r_sel;
  logic                        r_lk0;
  logic [SEQ_CNT_DW-1:0]       r_seq_cnt;
  logic                        r_in_ready;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_ena;
  logic [L-1:0]                r_wea;
  logic [L*RSA_DW-1:0]         r_dina;
  logic [CB_AW-1:0]            r_addra;

  logic                        w_accept;
  logic                        w_last;
  logic [L*RSA_DW-1:0]         w_dina;
  logic [L-1:0]                w_wea;
  logic [CB_AW-1:0]            w_addr;

  assign w_accept = (r_state == S_RUN) && bus.in_valid;
  assign w_last   = w_accept && (r_seq_cnt == r_len - ONE_CNT);
  assign w_addr   = r_base + CB_AW'(r_seq_cnt);

  // State register
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Next-state logic; start is only honoured in IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (len == '0) ? S_FLUSH : S_RUN;
      S_RUN:   if (w_last) w_next = S_FLUSH;
      S_FLUSH: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Write-data formatting for the beat being accepted this cycle
  always_comb begin
    w_dina = '0;
    w_wea  = '0;
    if (r_sel[4:2] == 3'b100) begin
      case (r_sel[1:0])
        2'b01: begin
          w_dina = bus.TB_douta;
          w_wea  = '1;
        end
        2'b10: begin
          for (int i = 0; i < L; i++) begin
            if (i < X) w_dina[i*RSA_DW +: RSA_DW] = bus.TB_douta[(X-1-i)*RSA_DW +: RSA_DW];
            else       w_dina[i*RSA_DW +: RSA_DW] = bus.TB_douta[i*RSA_DW +: RSA_DW];
          end
          w_wea = '1;
        end
        2'b11: begin
          w_dina[0 +: 2*RSA_DW] = r_lk0 ? bus.TB_douta[0 +: 2*RSA_DW]
                                        : bus.TB_douta[2*RSA_DW +: 2*RSA_DW];
          w_wea[1:0] = 2'b11;
        end
        default: ;
      endcase
    end
  end

  // Output and configuration registers; status flags decode the upcoming state
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_base     <= '0;
      r_len      <= '0;
      r_sel      <= '0;
      r_lk0      <= 1'b0;
      r_seq_cnt  <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ena      <= 1'b0;
      r_wea      <= '0;
      r_dina     <= '0;
      r_addra    <= '0;
    end else begin
      r_in_ready <= (w_next == S_RUN);
      r_busy     <= (w_next != S_IDLE);
      r_done     <= (w_next == S_FLUSH);
      r_ena      <= w_accept;
      if (r_state == S_IDLE && start) begin
        r_base    <= base_addr;
        r_len     <= len;
        r_sel     <= CB_dina_sel;
        r_lk0     <= l_k_0;
        r_seq_cnt <= '0;
      end
      if (w_accept) begin
        r_addra   <= w_addr;
        r_dina    <= w_dina;
        r_wea     <= w_wea;
        r_seq_cnt <= r_seq_cnt + ONE_CNT;
      end else begin
        r_wea     <= '0;
      end
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.CB_dina  = r_dina;
  assign bus.CB_wea   = r_wea;
  assign bus.CB_ena   = r_ena;
  assign bus.CB_addra = r_addra;
  assign seq_cnt_out  = r_seq_cnt;
  assign busy         = r_busy;
  assign done         = r_done;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_cb_dina_wb.sv
// Directed bench for cb_dina_wb: pos/neg/new lane modes, back-pressure, wrap, len=0,
// ignored start, and reset mid-burst; CB writes are scored against an expected queue.
module tb_cb_dina_wb;

  localparam int W  = 128;
  localparam int EW = 10 + 4 + W;

  logic            clk = 1'b0;
  logic            sys_rst_n = 1'b0;
  logic            start = 1'b0;
  logic [9:0]      base_addr = '0;
  logic [9:0]      len = '0;
  logic [4:0]      CB_dina_sel = '0;
  logic            l_k_0 = 1'b0;
  logic [9:0]      seq_cnt_out;
  logic            busy;
  logic            done;
  logic [1:0]      dbg_state;

  int total = 0;
  int bad   = 0;

  logic [EW-1:0] exp_q[$];

  cb_dina_wb_if #(.L(4), .RSA_DW(32), .CB_AW(10)) bus ();

  cb_dina_wb dut (
    .clk         (clk),
    .sys_rst_n   (sys_rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .len         (len),
    .CB_dina_sel (CB_dina_sel),
    .l_k_0       (l_k_0),
    .bus         (bus),
    .seq_cnt_out (seq_cnt_out),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset-time watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [9:0] b, input logic [9:0] n,
                             input logic [4:0] s, input logic lk);
    bus.in_valid = 1'b0;
    start        = 1'b1;
    base_addr    = b;
    len          = n;
    CB_dina_sel  = s;
    l_k_0        = lk;
    tick();
    start        = 1'b0;
  endtask

  task automatic beat(input logic [W-1:0] d, input logic [9:0] a,
                      input logic [W-1:0] ed, input logic [3:0] ew);
    bus.in_valid = 1'b1;
    bus.TB_douta = d;
    exp_q.push_back({a, ew, ed});
    tick();
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && busy; i++) tick();
    chk(tag, busy, 1'b0);
  endtask

  // Scoreboard: every CB write must match the head of the expected queue
  always @(negedge clk) begin
    if (bus.CB_ena === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", bus.CB_ena, 1'b0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", bus.CB_addra, e[EW-1 -: 10]);
        chk("wr_wea",  bus.CB_wea,   e[W +: 4]);
        chk("wr_dina", bus.CB_dina,  e[W-1:0]);
      end
    end
  end

  localparam logic [W-1:0] WA = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
  localparam logic [W-1:0] WB = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
  localparam logic [W-1:0] WC = {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000};
  localparam logic [W-1:0] WD = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
  // Lanes {3,2,1,0} = {D,C,B,A}
  localparam logic [W-1:0] WL = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};

  initial begin
    bus.in_valid = 1'b0;
    bus.TB_douta = '0;

    // Reset state
    tick(); tick();
    chk("rst_ena",      bus.CB_ena,   1'b0);
    chk("rst_wea",      bus.CB_wea,   4'h0);
    chk("rst_dina",     bus.CB_dina,  128'h0);
    chk("rst_addra",    bus.CB_addra, 10'h0);
    chk("rst_seq",      seq_cnt_out,  10'h0);
    chk("rst_busy",     busy,         1'b0);
    chk("rst_done",     done,         1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    sys_rst_n = 1'b1;
    tick();

    // POS burst base=5 len=3
    start_burst(10'd5, 10'd3, 5'b10001, 1'b0);
    chk("pos_busy",     busy,         1'b1);
    chk("pos_in_ready", bus.in_ready, 1'b1);
    chk("pos_no_write", bus.CB_ena,   1'b0);
    beat(WA, 10'd5, WA, 4'hF);
    chk("pos_seq1", seq_cnt_out, 10'd1);
    beat(WB, 10'd6, WB, 4'hF);
    beat(WC, 10'd7, WC, 4'hF);
    chk("pos_done",      done,         1'b1);
    chk("pos_ena_last",  bus.CB_ena,   1'b1);
    chk("pos_seq3",      seq_cnt_out,  10'd3);
    chk("pos_ready_off", bus.in_ready, 1'b0);
    bus.TB_douta = WD;   // in_valid still high in FLUSH: must be ignored
    tick();
    chk("pos_done_clr", done,         1'b0);
    chk("pos_busy_clr", busy,         1'b0);
    chk("pos_ena_clr",  bus.CB_ena,   1'b0);
    chk("pos_wea_clr",  bus.CB_wea,   4'h0);
    chk("pos_hold_adr", bus.CB_addra, 10'd7);
    chk("pos_hold_dat", bus.CB_dina,  WC);
    bus.in_valid = 1'b0;
    tick();

    // NEG lane reversal
    start_burst(10'd20, 10'd1, 5'b10010, 1'b0);
    beat(WL, 10'd20, {32'hAAAA_0000, 32'hBBBB_0001, 32'hCCCC_0002, 32'hDDDD_0003}, 4'hF);
    wait_idle("neg_idle");

    // NEW mode, both halves
    start_burst(10'd30, 10'd1, 5'b10011, 1'b1);
    beat(WL, 10'd30, {64'h0, 32'hBBBB_0001, 32'hAAAA_0000}, 4'b0011);
    wait_idle("new1_idle");
    start_burst(10'd31, 10'd1, 5'b10011, 1'b0);
    beat(WL, 10'd31, {64'h0, 32'hDDDD_0003, 32'hCCCC_0002}, 4'b0011);
    wait_idle("new0_idle");

    // Non-writing selects still consume and address
    start_burst(10'd40, 10'd2, 5'b10000, 1'b0);
    beat(WA, 10'd40, 128'h0, 4'h0);
    beat(WB, 10'd41, 128'h0, 4'h0);
    wait_idle("dirz_idle");
    start_burst(10'd42, 10'd1, 5'b01001, 1'b0);
    beat(WC, 10'd42, 128'h0, 4'h0);
    chk("src_seq", seq_cnt_out, 10'd1);
    wait_idle("src_idle");

    // Back-pressure with address wrap
    start_burst(10'd1023, 10'd2, 5'b10001, 1'b0);
    beat(WA, 10'd1023, WA, 4'hF);
    chk("bp_seq1", seq_cnt_out, 10'd1);
    bus.in_valid = 1'b0;
    bus.TB_douta = WD;
    tick();
    chk("bp_gap_ena",  bus.CB_ena,   1'b0);
    chk("bp_gap_seq",  seq_cnt_out,  10'd1);
    chk("bp_gap_addr", bus.CB_addra, 10'd1023);
    chk("bp_gap_busy", busy,         1'b1);
    beat(WB, 10'd0, WB, 4'hF);
    chk("bp_seq2", seq_cnt_out, 10'd2);
    chk("bp_done", done,        1'b1);
    bus.in_valid = 1'b0;
    wait_idle("bp_idle");

    // start pulsed during RUN has no effect
    start_burst(10'd50, 10'd2, 5'b10001, 1'b0);
    start = 1'b1; base_addr = 10'd99; len = 10'd0;
    beat(WC, 10'd50, WC, 4'hF);
    start = 1'b0;
    beat(WD, 10'd51, WD, 4'hF);
    chk("rs_done", done,        1'b1);
    chk("rs_seq",  seq_cnt_out, 10'd2);
    bus.in_valid = 1'b0;
    wait_idle("rs_idle");

    // len=0: immediate done, no write; start in FLUSH ignored
    start_burst(10'd60, 10'd0, 5'b10001, 1'b0);
    chk("l0_done",  done,       1'b1);
    chk("l0_ena",   bus.CB_ena, 1'b0);
    chk("l0_ready", bus.in_ready, 1'b0);
    start = 1'b1; len = 10'd3; bus.in_valid = 1'b1;
    tick();
    start = 1'b0;
    chk("l0_flush_start_ign", busy, 1'b0);
    chk("l0_done_clr",        done, 1'b0);
    tick();
    chk("l0_still_idle", busy,       1'b0);
    chk("l0_no_write",   bus.CB_ena, 1'b0);
    bus.in_valid = 1'b0;

    // Reset mid-burst
    start_burst(10'd70, 10'd4, 5'b10001, 1'b0);
    beat(WA, 10'd70, WA, 4'hF);
    #5;                        // let the scoreboard see beat 1 before reset
    sys_rst_n = 1'b0;
    #1;
    chk("mr_ena",   bus.CB_ena,   1'b0);
    chk("mr_addr",  bus.CB_addra, 10'h0);
    chk("mr_dina",  bus.CB_dina,  128'h0);
    chk("mr_busy",  busy,         1'b0);
    chk("mr_seq",   seq_cnt_out,  10'h0);
    chk("mr_ready", bus.in_ready, 1'b0);
    tick(); tick();
    chk("mr_no_done", done, 1'b0);
    sys_rst_n = 1'b1;
    tick();
    chk("mr_idle_after", busy, 1'b0);
    chk("mr_no_write",   bus.CB_ena, 1'b0);
    bus.in_valid = 1'b0;
    start_burst(10'd80, 10'd2, 5'b10001, 1'b0);
    beat(WB, 10'd80, WB, 4'hF);
    beat(WC, 10'd81, WC, 4'hF);
    chk("mr_new_done", done, 1'b1);
    bus.in_valid = 1'b0;
    wait_idle("mr_new_idle");

    tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cb_dina_wb.md
CB_DINA_WB -- requirements
Module: cb_dina_wb

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- X 4: lane count used for lane reversal.
- L 4: lanes per word.
- RSA_DW 32: bits per lane.
- CB_AW 10: CB address width.
- SEQ_CNT_DW 10: beat counter width.
- CB_DINA_SEL_DW 5: select width.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock.
- sys_rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse that launches a write-back burst.
- base_addr  in  CB_AW  first CB address of the burst.
- len  in  SEQ_CNT_DW  number of beats in the burst.
- CB_dina_sel  in  CB_DINA_SEL_DW  [4:2] source, [1:0] direction.
- l_k_0  in  1  NEW-mode half select.
- in_valid  in  1  TB_douta word valid.
- in_ready  out  1  block accepts a word.
- TB_douta  in  L*RSA_DW  TB read data; lane i is bits [i*RSA_DW +: RSA_DW].
- CB_dina  out  L*RSA_DW  CB write data.
- CB_wea  out  L  per-lane CB write enable.
- CB_ena  out  1  CB port enable.
- CB_addra  out  CB_AW  CB write address.
- seq_cnt_out  out  SEQ_CNT_DW  count of beats accepted so far.
- busy  out  1  burst in progress.
- done  out  1  one-cycle completion pulse.

Function
REQ-003 FSM states: IDLE, RUN, FLUSH.
REQ-004 IDLE with start=1 and len!=0 -> RUN.
- Latch base_addr, len, CB_dina_sel and l_k_0 in that cycle.
- Clear seq_cnt_out.
REQ-005 IDLE with start=1 and len=0 -> FLUSH; no CB write occurs.
REQ-006 start is ignored in RUN and FLUSH.
REQ-007 in_ready = 1 only in RUN.
- A beat is accepted when in_valid && in_ready.
- in_valid outside RUN is ignored.
REQ-008 Each accepted beat, one cycle later:
- CB_ena = 1.
- CB_addra = latched base + beat index, modulo 2^CB_AW (wraps).
- CB_dina and CB_wea per REQ-010..REQ-013.
- seq_cnt_out increments at acceptance.
REQ-009 When the beat with index len-1 is accepted, RUN -> FLUSH.
- In FLUSH: done = 1 for one cycle, coincident with the last CB_ena (or with no CB_ena when len=0).
- Next state: IDLE.
REQ-010 Source field 3'b100, direction POS (01):
- CB_dina = TB_douta.
- CB_wea = all ones.
REQ-011 Source field 3'b100, direction NEG (10):
- CB_dina lane i = TB_douta lane X-1-i, for i = 0..X-1.
- CB_wea = all ones.
REQ-012 Source field 3'b100, direction NEW (11):
- l_k_0=1: CB_dina lanes 0,1 = TB_douta lanes 0,1.
- l_k_0=0: CB_dina lanes 0,1 = TB_douta lanes 2,3.
- In both cases lanes 2,3 = 0 and CB_wea = 4'b0011.
REQ-013 Direction IDLE (00), or any source field other than 3'b100:
- Beats are still accepted and counted.
- CB_dina = 0, CB_wea = 0, CB_ena = 1 with the address still advancing.
REQ-014 Cycles with no accepted beat: CB_ena = 0, CB_wea = 0; CB_dina and CB_addra hold their values.
REQ-015 busy = 1 in RUN and FLUSH, 0 in IDLE.
REQ-016 All outputs are registered. Latency from accept to CB write is exactly 1 cycle.
REQ-017 Throughput is one beat per cycle while in_valid stays high.
REQ-018 start arriving in the FLUSH cycle is ignored; a new burst needs start while in IDLE.

Reset
REQ-019 sys_rst_n=0 asynchronously forces:
- State = IDLE.
- CB_dina = 0, CB_wea = 0, CB_ena = 0, CB_addra = 0.
- seq_cnt_out = 0, busy = 0, done = 0, in_ready = 0.
- All latched configuration cleared.
REQ-020 Reset asserted mid-burst aborts the burst.
- No further CB writes and no done pulse.
- After release the block waits in IDLE for start.

Verification
REQ-021 POS burst: base=5, len=3, sel=5'b10001, in_valid held, words A,B,C.
- Expected: CB_ena on 3 consecutive cycles.
- Addresses 5,6,7; data A,B,C; CB_wea=4'hF.
- done coincident with the write of C; busy drops the next cycle.
REQ-022 NEG: sel=5'b10010, TB_douta lanes {3,2,1,0}={D,C,B,A}.
- Expected: CB_dina lanes {3,2,1,0}={A,B,C,D}, CB_wea=4'hF.
REQ-023 NEW: sel=5'b10011, lanes {3,2,1,0}={D,C,B,A}.
- l_k_0=1: CB_dina={0,0,B,A}, CB_wea=4'b0011.
- l_k_0=0: CB_dina={0,0,D,C}, CB_wea=4'b0011.
REQ-024 Back-pressure and wrap: base=1023, len=2, in_valid toggled 1,0,1.
- Expected: writes to addresses 1023 then 0.
- No CB_ena in the gap cycle.
- seq_cnt_out reads 1 then 2.
REQ-025 Edge cases:
- len=0: done one cycle after start, CB_ena never asserted.
- start pulsed during RUN: no effect on the burst in progress.
REQ-026 Reset mid-burst: sys_rst_n low after beat 1 of len=4.
- Expected: outputs 0 immediately, no done pulse.
- A new burst after release completes normally.
